// File: rtl/phy_link_ctrl.sv
// Link-sequencing controller for the PHY byte path: comma-count sync acquisition,
// error-driven loss of sync, comma stripping on RX, and comma/data selection on TX.
module phy_link_ctrl #(
  parameter logic [7:0] COMMA       = 8'hBC,
  parameter int         SYNC_COMMAS = 4,
  parameter int         ERR_MAX     = 3,
  parameter int         GOOD_RUN    = 4
) (
  input  logic       clk_4f,
  input  logic       reset,
  input  logic       en,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       rx_err,
  input  logic [7:0] tx_in_data,
  input  logic       tx_in_valid,
  output logic       tx_ready,
  output logic [7:0] tx_data,
  output logic       tx_is_idle,
  output logic [7:0] rx_out_data,
  output logic       rx_out_valid,
  output logic       link_up,
  output logic [1:0] state
);

  localparam logic [1:0] ST_SEARCH = 2'b00;
  localparam logic [1:0] ST_SYNCED = 2'b01;

  localparam logic [4:0] SYNC_LIM = 5'(SYNC_COMMAS);
  localparam logic [4:0] ERR_LIM  = 5'(ERR_MAX);
  localparam logic [4:0] GOOD_LIM = 5'(GOOD_RUN);

  logic [1:0] state_q, state_d;
  logic [3:0] comma_cnt_q, comma_cnt_d;
  logic [3:0] err_cnt_q, err_cnt_d;
  logic [3:0] good_cnt_q, good_cnt_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic       tx_is_idle_q, tx_is_idle_d;
  logic [7:0] rx_out_data_q, rx_out_data_d;
  logic       rx_out_valid_q, rx_out_valid_d;

  logic       synced;
  logic       is_comma;
  logic [4:0] comma_inc;
  logic [4:0] err_inc;
  logic [4:0] good_inc;

  assign synced    = (state_q == ST_SYNCED);
  assign is_comma  = (rx_data == COMMA);
  assign comma_inc = {1'b0, comma_cnt_q} + 5'd1;
  assign err_inc   = {1'b0, err_cnt_q} + 5'd1;
  assign good_inc  = {1'b0, good_cnt_q} + 5'd1;

  // NOTE: every _d gets a default before any branch so no path leaves it unassigned (no latches).
  always_comb begin
    state_d        = state_q;
    comma_cnt_d    = comma_cnt_q;
    err_cnt_d      = err_cnt_q;
    good_cnt_d     = good_cnt_q;
    rx_out_data_d  = rx_out_data_q;
    rx_out_valid_d = 1'b0;
    tx_data_d      = COMMA;
    tx_is_idle_d   = 1'b1;

    // tx_ready is the pre-edge link state, so a byte offered on the dropping edge still goes out.
    if (synced && tx_in_valid) begin
      tx_data_d    = tx_in_data;
      tx_is_idle_d = 1'b0;
    end

    case (state_q)
      ST_SEARCH: begin
        if (rx_valid) begin
          if (is_comma && !rx_err) begin
            if (comma_inc == SYNC_LIM) begin
              state_d     = ST_SYNCED;
              comma_cnt_d = '0;
              err_cnt_d   = '0;
              good_cnt_d  = '0;
            end else if (comma_cnt_q != 4'hF) begin
              comma_cnt_d = comma_inc[3:0];
            end
          end else begin
            comma_cnt_d = '0;
          end
        end
      end
      ST_SYNCED: begin
        if (rx_valid) begin
          if (rx_err) begin
            good_cnt_d = '0;
            if (err_inc == ERR_LIM) begin
              state_d     = ST_SEARCH;
              comma_cnt_d = '0;
              err_cnt_d   = '0;
            end else if (err_cnt_q != 4'hF) begin
              err_cnt_d = err_inc[3:0];
            end
          end else begin
            if (good_inc == GOOD_LIM) begin
              good_cnt_d = '0;
              if (err_cnt_q != 4'd0) err_cnt_d = err_cnt_q - 4'd1;
            end else if (good_cnt_q != 4'hF) begin
              good_cnt_d = good_inc[3:0];
            end
            if (!is_comma) begin
              rx_out_data_d  = rx_data;
              rx_out_valid_d = 1'b1;
            end
          end
        end
      end
      default: begin
        state_d     = ST_SEARCH;
        comma_cnt_d = '0;
        err_cnt_d   = '0;
        good_cnt_d  = '0;
      end
    endcase

    if (!en) begin
      state_d        = ST_SEARCH;
      comma_cnt_d    = '0;
      err_cnt_d      = '0;
      good_cnt_d     = '0;
      rx_out_data_d  = '0;
      rx_out_valid_d = 1'b0;
      tx_data_d      = COMMA;
      tx_is_idle_d   = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk_4f or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_SEARCH;
      comma_cnt_q    <= '0;
      err_cnt_q      <= '0;
      good_cnt_q     <= '0;
      tx_data_q      <= COMMA;
      tx_is_idle_q   <= 1'b1;
      rx_out_data_q  <= '0;
      rx_out_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      comma_cnt_q    <= comma_cnt_d;
      err_cnt_q      <= err_cnt_d;
      good_cnt_q     <= good_cnt_d;
      tx_data_q      <= tx_data_d;
      tx_is_idle_q   <= tx_is_idle_d;
      rx_out_data_q  <= rx_out_data_d;
      rx_out_valid_q <= rx_out_valid_d;
    end
  end

  assign state        = state_q;
  assign link_up      = synced;
  assign tx_ready     = synced;
  assign tx_data      = tx_data_q;
  assign tx_is_idle   = tx_is_idle_q;
  assign rx_out_data  = rx_out_data_q;
  assign rx_out_valid = rx_out_valid_q;

endmodule

// File: tb/tb_phy_link_ctrl.sv
// Directed, table-driven bench for phy_link_ctrl: vector table for sync/forward/TX,
// hand-written sequences for error accounting, link drop and asynchronous reset.
module tb_phy_link_ctrl;

  logic       clk_4f = 1'b0;
  logic       reset;
  logic       en;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_err;
  logic [7:0] tx_in_data;
  logic       tx_in_valid;
  logic       tx_ready;
  logic [7:0] tx_data;
  logic       tx_is_idle;
  logic [7:0] rx_out_data;
  logic       rx_out_valid;
  logic       link_up;
  logic [1:0] state;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string      name;
    logic       en;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_err;
    logic [7:0] tx_in_data;
    logic       tx_in_valid;
    logic       exp_link;
    logic [1:0] exp_state;
    logic [7:0] exp_tx_data;
    logic       exp_tx_idle;
    logic       exp_rov;
    logic [7:0] exp_rod;
  } vec_t;

  vec_t vecs[$];

  phy_link_ctrl dut (
    .clk_4f      (clk_4f),
    .reset       (reset),
    .en          (en),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_err      (rx_err),
    .tx_in_data  (tx_in_data),
    .tx_in_valid (tx_in_valid),
    .tx_ready    (tx_ready),
    .tx_data     (tx_data),
    .tx_is_idle  (tx_is_idle),
    .rx_out_data (rx_out_data),
    .rx_out_valid(rx_out_valid),
    .link_up     (link_up),
    .state       (state)
  );

  always #5 clk_4f = ~clk_4f;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Apply one byte slot, then sample 1 time unit after the rising edge.
  task automatic step(input logic e, input logic [7:0] rd, input logic rv, input logic re,
                      input logic [7:0] td, input logic tv);
    en          = e;
    rx_data     = rd;
    rx_valid    = rv;
    rx_err      = re;
    tx_in_data  = td;
    tx_in_valid = tv;
    @(posedge clk_4f);
    #1;
  endtask

  task automatic add(input string n, input logic e, input logic [7:0] rd, input logic rv,
                     input logic re, input logic [7:0] td, input logic tv, input logic lk,
                     input logic [1:0] st, input logic [7:0] txd, input logic txi,
                     input logic rov, input logic [7:0] rod);
    vec_t v;
    v.name = n; v.en = e; v.rx_data = rd; v.rx_valid = rv; v.rx_err = re;
    v.tx_in_data = td; v.tx_in_valid = tv; v.exp_link = lk; v.exp_state = st;
    v.exp_tx_data = txd; v.exp_tx_idle = txi; v.exp_rov = rov; v.exp_rod = rod;
    vecs.push_back(v);
  endtask

  task automatic lock4();
    for (int i = 0; i < 4; i++) step(1'b1, 8'hBC, 1'b1, 1'b0, 8'h00, 1'b0);
    check("lock4_link_up", 32'(link_up), 32'd1);
  endtask

  initial begin
    reset = 1'b0; en = 1'b0; rx_data = '0; rx_valid = 1'b0; rx_err = 1'b0;
    tx_in_data = '0; tx_in_valid = 1'b0;
    #12;
    check("rst_state", 32'(state), 32'd0);
    check("rst_link_up", 32'(link_up), 32'd0);
    check("rst_tx_ready", 32'(tx_ready), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'hBC);
    check("rst_tx_idle", 32'(tx_is_idle), 32'd1);
    check("rst_rov", 32'(rx_out_valid), 32'd0);
    check("rst_rod", 32'(rx_out_data), 32'd0);
    @(negedge clk_4f);
    reset = 1'b1;

    //   name          en rx_data v err tx_in v  link st  tx_data idle rov rod
    add("srch_bc1",    1, 8'hBC, 1, 0, 8'h3C, 1, 0, 2'd0, 8'hBC, 1, 0, 8'h00);
    add("srch_bc2",    1, 8'hBC, 1, 0, 8'h3C, 1, 0, 2'd0, 8'hBC, 1, 0, 8'h00);
    add("srch_bc3",    1, 8'hBC, 1, 0, 8'h3C, 1, 0, 2'd0, 8'hBC, 1, 0, 8'h00);
    add("srch_55",     1, 8'h55, 1, 0, 8'h3C, 1, 0, 2'd0, 8'hBC, 1, 0, 8'h00);
    add("srch_bc5",    1, 8'hBC, 1, 0, 8'h3C, 1, 0, 2'd0, 8'hBC, 1, 0, 8'h00);
    add("srch_bc6",    1, 8'hBC, 1, 0, 8'h3C, 1, 0, 2'd0, 8'hBC, 1, 0, 8'h00);
    add("srch_bc7",    1, 8'hBC, 1, 0, 8'h3C, 1, 0, 2'd0, 8'hBC, 1, 0, 8'h00);
    add("lock_bc8",    1, 8'hBC, 1, 0, 8'h3C, 1, 1, 2'd1, 8'hBC, 1, 0, 8'h00);
    add("sync_bc_tx",  1, 8'hBC, 1, 0, 8'h3C, 1, 1, 2'd1, 8'h3C, 0, 0, 8'h00);
    add("sync_a1",     1, 8'hA1, 1, 0, 8'h3C, 0, 1, 2'd1, 8'hBC, 1, 1, 8'hA1);
    add("sync_bc",     1, 8'hBC, 1, 0, 8'h5A, 1, 1, 2'd1, 8'h5A, 0, 0, 8'hA1);
    add("sync_b2",     1, 8'hB2, 1, 0, 8'h5A, 0, 1, 2'd1, 8'hBC, 1, 1, 8'hB2);
    add("sync_novld",  1, 8'h77, 0, 0, 8'hBC, 1, 1, 2'd1, 8'hBC, 0, 0, 8'hB2);
    add("en_low",      0, 8'h66, 1, 0, 8'h11, 1, 0, 2'd0, 8'hBC, 1, 0, 8'h00);

    foreach (vecs[i]) begin
      step(vecs[i].en, vecs[i].rx_data, vecs[i].rx_valid, vecs[i].rx_err,
           vecs[i].tx_in_data, vecs[i].tx_in_valid);
      check({vecs[i].name, "_link_up"}, 32'(link_up), 32'(vecs[i].exp_link));
      check({vecs[i].name, "_tx_ready"}, 32'(tx_ready), 32'(vecs[i].exp_link));
      check({vecs[i].name, "_state"}, 32'(state), 32'(vecs[i].exp_state));
      check({vecs[i].name, "_tx_data"}, 32'(tx_data), 32'(vecs[i].exp_tx_data));
      check({vecs[i].name, "_tx_idle"}, 32'(tx_is_idle), 32'(vecs[i].exp_tx_idle));
      check({vecs[i].name, "_rov"}, 32'(rx_out_valid), 32'(vecs[i].exp_rov));
      check({vecs[i].name, "_rod"}, 32'(rx_out_data), 32'(vecs[i].exp_rod));
    end

    // Errored comma and invalid slots in SEARCH.
    for (int i = 0; i < 3; i++) step(1'b1, 8'hBC, 1'b1, 1'b0, 8'h00, 1'b0);
    step(1'b1, 8'hBC, 1'b1, 1'b1, 8'h00, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 8'hBC, 1'b1, 1'b0, 8'h00, 1'b0);
    check("errcomma_no_lock", 32'(link_up), 32'd0);
    step(1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
    check("invalid_no_change", 32'(link_up), 32'd0);
    step(1'b1, 8'hBC, 1'b1, 1'b0, 8'h00, 1'b0);
    check("errcomma_lock", 32'(link_up), 32'd1);

    // Errors 2, clean 4 (err 2->1), errors 2 (1->2->3): drop on final error.
    step(1'b1, 8'h00, 1'b1, 1'b1, 8'h00, 1'b0);
    step(1'b1, 8'h00, 1'b1, 1'b1, 8'h00, 1'b0);
    check("e2_still_up", 32'(link_up), 32'd1);
    check("e2_no_fwd", 32'(rx_out_valid), 32'd0);
    for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h10 + i), 1'b1, 1'b0, 8'h00, 1'b0);
    check("clean_fwd_valid", 32'(rx_out_valid), 32'd1);
    check("clean_fwd_data", 32'(rx_out_data), 32'h13);
    step(1'b1, 8'h00, 1'b1, 1'b1, 8'h00, 1'b0);
    check("e3_still_up", 32'(link_up), 32'd1);
    step(1'b1, 8'h00, 1'b1, 1'b1, 8'h99, 1'b1);
    check("e4_drop_link", 32'(link_up), 32'd0);
    check("e4_drop_state", 32'(state), 32'd0);
    check("e4_drop_tx_ready", 32'(tx_ready), 32'd0);
    check("drop_edge_tx_data", 32'(tx_data), 32'h99);
    check("drop_edge_tx_idle", 32'(tx_is_idle), 32'd0);
    step(1'b1, 8'h00, 1'b0, 1'b0, 8'h3C, 1'b1);
    check("after_drop_tx_data", 32'(tx_data), 32'hBC);
    check("after_drop_tx_idle", 32'(tx_is_idle), 32'd1);

    // Three back-to-back errors.
    lock4();
    step(1'b1, 8'h00, 1'b1, 1'b1, 8'h00, 1'b0);
    step(1'b1, 8'h00, 1'b1, 1'b1, 8'h00, 1'b0);
    check("b2b_e2_up", 32'(link_up), 32'd1);
    step(1'b1, 8'h00, 1'b1, 1'b1, 8'h00, 1'b0);
    check("b2b_e3_down", 32'(link_up), 32'd0);

    // Asynchronous reset mid-stream while linked and forwarding.
    lock4();
    step(1'b1, 8'hC4, 1'b1, 1'b0, 8'h3C, 1'b1);
    check("pre_rst_rov", 32'(rx_out_valid), 32'd1);
    check("pre_rst_tx_data", 32'(tx_data), 32'h3C);
    #2 reset = 1'b0;
    #1;
    check("arst_state", 32'(state), 32'd0);
    check("arst_link_up", 32'(link_up), 32'd0);
    check("arst_tx_ready", 32'(tx_ready), 32'd0);
    check("arst_tx_data", 32'(tx_data), 32'hBC);
    check("arst_tx_idle", 32'(tx_is_idle), 32'd1);
    check("arst_rov", 32'(rx_out_valid), 32'd0);
    check("arst_rod", 32'(rx_out_data), 32'd0);
    @(negedge clk_4f);
    reset = 1'b1;
    step(1'b1, 8'hBC, 1'b1, 1'b0, 8'h00, 1'b0);
    check("post_rst_count_restart", 32'(link_up), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
